stage2_conv_ch_scheduler: RTL
=============================

Name: stage2_conv_ch_scheduler

Overview:
Sequences the stage-2 5x5 kernel MAC over every (output filter, input channel) pair for one window position. It issues back-to-back kernel invocations and supplies weight/fmap select indices to external muxes. It accumulates the in-order kernel results across input channels, adds the per-filter bias, and emits one stage-2 conv sum per filter. It sits between the stage-2 window buffer/weight ROM and the stage-2 ReLU/pool stage.

Parameters:
IN_CH, 3, input channels summed per output
OUT_CH, 3, output filters per window
AK_BW, 32, width of kernel result (signed)
B_BW, 16, width of bias (signed)
ACC_BW, 36, width of output sum (signed); must be >= AK_BW+clog2(IN_CH)+1
IDX_BW, 4, width of channel/filter index ports

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
i_start  in  1  window ready pulse; accepted only in IDLE
o_busy  out  1  high from cycle after accepted i_start until cycle after o_done
o_kern_valid  out  1  issue strobe to kernel i_in_valid
o_fmap_ch  out  IDX_BW  input-channel select for window mux, valid with o_kern_valid
o_wgt_filt  out  IDX_BW  filter select for weight mux, valid with o_kern_valid
i_kern_valid  in  1  kernel result strobe
i_kern_acc  in  AK_BW  kernel result, signed
o_bias_idx  out  IDX_BW  filter whose result is being accumulated (bias lookup select)
i_bias  in  B_BW  signed bias for o_bias_idx, combinational from outside
o_ot_valid  out  1  output sum strobe
o_ot_filt  out  IDX_BW  filter index of o_ot_acc
o_ot_acc  out  ACC_BW  sum of IN_CH kernel results + bias, signed
o_done  out  1  one-cycle pulse with last o_ot_valid of the window
o_err  out  1  sticky: unexpected i_kern_valid outside ISSUE/DRAIN; cleared only by reset

Behaviour:
- Reset: every output and register = 0; FSM = IDLE.
- Synchronous active-high reset mid-operation: aborts immediately. Counters, accumulator and FSM clear. Kernel results still in flight afterwards arrive in IDLE and set o_err (the upstream kernel is reset together).
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: i_start=1 -> ISSUE; issue counters filt=0, ch=0; result counters cleared.
- ISSUE: o_kern_valid=1 every cycle, registered, so the first strobe appears 1 cycle after i_start.
  - Order is filter-major: (f0,c0),(f0,c1)...(f0,cIN_CH-1),(f1,c0)...
  - Exactly IN_CH*OUT_CH strobes, no gaps. After the last strobe -> DRAIN.
  - o_fmap_ch/o_wgt_filt hold the issued pair; they hold their last value when o_kern_valid=0.
- Result path (ISSUE and DRAIN): results arrive in issue order.
  - Result counters res_ch/res_filt; o_bias_idx = res_filt.
  - On i_kern_valid with res_ch<IN_CH-1: acc += sign-extended i_kern_acc; res_ch++.
  - On i_kern_valid with res_ch==IN_CH-1: next cycle o_ot_valid=1, o_ot_filt=res_filt, o_ot_acc = acc + i_kern_acc + sext(i_bias). Then acc=0, res_ch=0, res_filt++.
  - Arithmetic is full precision, no saturation/rounding. ACC_BW sizing guarantees no overflow.
- DRAIN: once the OUT_CH-th output is registered, o_done=1 in the same cycle as that o_ot_valid, FSM -> IDLE, and o_busy drops on the following cycle.
- i_start while busy: ignored, no effect.
- i_start in the same cycle the FSM returns to IDLE: ignored. It is accepted from the next cycle onward.
- i_kern_valid in IDLE: ignored for accumulation; o_err=1.
- o_ot_valid/o_done are single-cycle pulses. No backpressure: the consumer must accept every strobe.
- Throughput: one window per IN_CH*OUT_CH + KERN_LAT + 2 cycles minimum.

Test Plan:
- Basic window: bench uses a 28-cycle delay kernel model; IN_CH=OUT_CH=3; kernel returns 10*f+c; bias f*100; i_start at t0.
  - o_kern_valid at t1..t9 with pairs (0,0)...(2,2).
  - o_ot_valid at t32/t35/t38 with acc 3, 133, 263 and filt 0,1,2.
  - o_done at t38; o_busy low at t39.
- Signed extremes: all kernel results = -2^31, bias = -2^15 -> o_ot_acc = 3*(-2^31)-32768 exactly, no wrap.
- i_start pulses at t3 and t38 during busy: ignored, identical outputs to the basic window. i_start at t40 starts a new window with first issue at t41.
- Reset asserted at t15: all outputs 0 at t16 and no o_ot_valid afterwards. Later model results set o_err=1, and o_err stays 1 until the next reset.
- Stray i_kern_valid in IDLE with value 5: o_err=1 and the next window's sums are unaffected, i.e. the accumulator was not polluted.
- Parameter sweep IN_CH=1, OUT_CH=4: 4 consecutive issues, each output = result+bias, o_done with the 4th output.

Source files
------------

// File: rtl/stage2_conv_ch_scheduler.sv
// Stage-2 convolution channel scheduler.
//
// Issues one 5x5 kernel MAC per (filter, input channel) pair for a single window position.
// Pairs are issued filter-major and back-to-back. In-order kernel results are summed across
// input channels, the per-filter bias is added, and one conv sum per filter is emitted.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   i_start                window ready pulse, accepted only in IDLE
//   o_busy                 window in progress
//   o_kern_valid           kernel issue strobe
//   o_fmap_ch, o_wgt_filt  channel/filter selects for the issued pair (held between strobes)
//   i_kern_valid           kernel result strobe
//   i_kern_acc             signed kernel result
//   o_bias_idx             filter currently being accumulated (bias lookup select)
//   i_bias                 signed bias for o_bias_idx, combinational from outside
//   o_ot_valid             output sum strobe
//   o_ot_filt              filter index of o_ot_acc
//   o_ot_acc               signed sum of IN_CH kernel results plus bias
//   o_done                 pulses with the last o_ot_valid of the window
//   o_err                  sticky flag for a kernel result seen while idle
module stage2_conv_ch_scheduler #(
   parameter int unsigned IN_CH  = 3,
   parameter int unsigned OUT_CH = 3,
   parameter int unsigned AK_BW  = 32,
   parameter int unsigned B_BW   = 16,
   parameter int unsigned ACC_BW = 36,
   parameter int unsigned IDX_BW = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_kern_valid,
   output logic [IDX_BW-1:0] o_fmap_ch,
   output logic [IDX_BW-1:0] o_wgt_filt,
   input  logic              i_kern_valid,
   input  logic [AK_BW-1:0]  i_kern_acc,
   output logic [IDX_BW-1:0] o_bias_idx,
   input  logic [B_BW-1:0]   i_bias,
   output logic              o_ot_valid,
   output logic [IDX_BW-1:0] o_ot_filt,
   output logic [ACC_BW-1:0] o_ot_acc,
   output logic              o_done,
   output logic              o_err
);

   localparam logic [IDX_BW-1:0] LAST_CH   = IDX_BW'(IN_CH - 1);
   localparam logic [IDX_BW-1:0] LAST_FILT = IDX_BW'(OUT_CH - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_t;

   state_t state_q, state_d;

   logic              iss_valid_q, iss_valid_d;
   logic [IDX_BW-1:0] iss_ch_q, iss_ch_d;
   logic [IDX_BW-1:0] iss_filt_q, iss_filt_d;

   logic [IDX_BW-1:0] res_ch_q;
   logic [IDX_BW-1:0] res_filt_q;
   logic [ACC_BW-1:0] acc_q;

   logic              ot_valid_q;
   logic [IDX_BW-1:0] ot_filt_q;
   logic [ACC_BW-1:0] ot_acc_q;
   logic              done_q;
   logic              err_q;

   logic [ACC_BW-1:0] kern_ext;
   logic [ACC_BW-1:0] bias_ext;
   logic              start_ok;
   logic              res_accept;
   logic              res_last_ch;

   assign kern_ext    = {{(ACC_BW - AK_BW){i_kern_acc[AK_BW-1]}}, i_kern_acc};
   assign bias_ext    = {{(ACC_BW - B_BW){i_bias[B_BW-1]}}, i_bias};
   assign start_ok    = (state_q == StIdle) && i_start;
   assign res_accept  = i_kern_valid && (state_q != StIdle);
   assign res_last_ch = (res_ch_q == LAST_CH);

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and issue sequencing
   always_comb begin
      state_d     = state_q;
      iss_valid_d = 1'b0;
      iss_ch_d    = iss_ch_q;
      iss_filt_d  = iss_filt_q;
      unique case (state_q)
         StIdle: begin
            if (i_start) begin
               state_d     = StIssue;
               iss_valid_d = 1'b1;
               iss_ch_d    = '0;
               iss_filt_d  = '0;
            end
         end
         StIssue: begin
            // The pair currently on the outputs is always a valid issue in this state.
            if ((iss_ch_q == LAST_CH) && (iss_filt_q == LAST_FILT)) begin
               state_d = StDrain;
            end else begin
               iss_valid_d = 1'b1;
               if (iss_ch_q == LAST_CH) begin
                  iss_ch_d   = '0;
                  iss_filt_d = iss_filt_q + IDX_BW'(1);
               end else begin
                  iss_ch_d = iss_ch_q + IDX_BW'(1);
               end
            end
         end
         StDrain: begin
            // Leave only once the final sum has been presented, so busy covers the done cycle.
            if (done_q) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Issue registers
   always_ff @(posedge clk) begin
      if (reset) begin
         iss_valid_q <= 1'b0;
         iss_ch_q    <= '0;
         iss_filt_q  <= '0;
      end else begin
         iss_valid_q <= iss_valid_d;
         iss_ch_q    <= iss_ch_d;
         iss_filt_q  <= iss_filt_d;
      end
   end

   // Result accumulation and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         res_ch_q   <= '0;
         res_filt_q <= '0;
         acc_q      <= '0;
         ot_valid_q <= 1'b0;
         ot_filt_q  <= '0;
         ot_acc_q   <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         ot_valid_q <= 1'b0;
         done_q     <= 1'b0;
         if (start_ok) begin
            res_ch_q   <= '0;
            res_filt_q <= '0;
            acc_q      <= '0;
         end else if (res_accept) begin
            if (!res_last_ch) begin
               acc_q    <= acc_q + kern_ext;
               res_ch_q <= res_ch_q + IDX_BW'(1);
            end else begin
               ot_valid_q <= 1'b1;
               ot_filt_q  <= res_filt_q;
               ot_acc_q   <= acc_q + kern_ext + bias_ext;
               acc_q      <= '0;
               res_ch_q   <= '0;
               if (res_filt_q == LAST_FILT) begin
                  done_q     <= 1'b1;
                  res_filt_q <= '0;
               end else begin
                  res_filt_q <= res_filt_q + IDX_BW'(1);
               end
            end
         end
         if (i_kern_valid && (state_q == StIdle)) begin
            err_q <= 1'b1;
         end
      end
   end

   assign o_busy       = (state_q != StIdle);
   assign o_kern_valid = iss_valid_q;
   assign o_fmap_ch    = iss_ch_q;
   assign o_wgt_filt   = iss_filt_q;
   assign o_bias_idx   = res_filt_q;
   assign o_ot_valid   = ot_valid_q;
   assign o_ot_filt    = ot_filt_q;
   assign o_ot_acc     = ot_acc_q;
   assign o_done       = done_q;
   assign o_err        = err_q;

endmodule
